// File: rtl/miss_mem_ctrl.sv
// Main-memory controller: 128-bit block refills after a fixed array latency, word write-throughs
// absorbed by a FIFO write buffer; refills wait for the buffer to drain so they see all earlier writes.
module miss_mem_ctrl #(
  parameter int WORDS      = 1024,
  parameter int LATENCY    = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         readmiss,
  input  logic         memwritethru,
  input  logic [31:0]  address,
  input  logic [31:0]  datawrite,
  output logic [127:0] datareadmiss,
  output logic         readready,
  output logic         writeready,
  output logic         busy
);

  localparam int AW = $clog2(WORDS);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [PW:0]   FULL = (PW+1)'(WBUF_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-3:0]   base_q, base_d;
  logic            rm_q, wt_q;
  logic [PW:0]     fill_q, fill_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic            pend_vld_q, pend_vld_d;
  logic [AW-1:0]   pend_idx_q;
  logic [31:0]     pend_dat_q;
  logic [127:0]    blk_q;
  logic            readready_q, writeready_q, busy_q;

  logic [AW-1:0]   fifo_idx [WBUF_DEPTH];
  logic [31:0]     fifo_dat [WBUF_DEPTH];
  logic [31:0]     mem      [WORDS];

  logic            rd_req, wr_req, deq, space, enq_pend, enq_new, enq, load;
  logic [AW-1:0]   req_idx, enq_idx;
  logic [31:0]     enq_dat;
  logic [127:0]    blk_rd;
  logic            unused_addr;

  assign unused_addr = ^{address[31:AW+2], address[1:0]};

  assign rd_req  = readmiss & ~rm_q;
  assign wr_req  = memwritethru & ~wt_q;
  assign req_idx = address[AW+1:2];

  // A full buffer still has room if its head drains on this same edge.
  assign deq      = ((state_q == IDLE) || (state_q == DRAIN)) && (fill_q != '0);
  assign space    = (fill_q != FULL) || deq;
  assign enq_pend = pend_vld_q && space;
  assign enq_new  = wr_req && !pend_vld_q && space;
  assign enq      = enq_pend || enq_new;
  assign enq_idx  = pend_vld_q ? pend_idx_q : req_idx;
  assign enq_dat  = pend_vld_q ? pend_dat_q : datawrite;
  assign fill_d   = fill_q + (PW+1)'(enq) - (PW+1)'(deq);

  always_comb begin
    pend_vld_d = pend_vld_q;
    if (enq_pend)
      pend_vld_d = 1'b0;
    else if (wr_req && !pend_vld_q && !space)
      pend_vld_d = 1'b1;
  end

  always_comb begin
    blk_rd = '0;
    for (int i = 0; i < 4; i++)
      blk_rd[32*i +: 32] = mem[{base_q, 2'(i)}];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = DRAIN;
          base_d  = address[AW+1:4];
        end
      end
      DRAIN: begin
        if ((fill_q == '0) && !pend_vld_q) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST) begin
          state_d = RESP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      rm_q         <= 1'b0;
      wt_q         <= 1'b0;
      fill_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      pend_vld_q   <= 1'b0;
      pend_idx_q   <= '0;
      pend_dat_q   <= '0;
      blk_q        <= '0;
      readready_q  <= 1'b0;
      writeready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      rm_q         <= readmiss;
      wt_q         <= memwritethru;
      fill_q       <= fill_d;
      pend_vld_q   <= pend_vld_d;
      readready_q  <= load;
      writeready_q <= enq;
      busy_q       <= (state_d != IDLE) || (fill_d != '0) || pend_vld_d;
      if (enq)
        wptr_q <= wptr_q + PW'(1);
      if (deq)
        rptr_q <= rptr_q + PW'(1);
      if (wr_req && !pend_vld_q && !space) begin
        pend_idx_q <= req_idx;
        pend_dat_q <= datawrite;
      end
      if (load)
        blk_q <= blk_rd;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and fill count.
  always_ff @(posedge Clk) begin
    if (enq) begin
      fifo_idx[wptr_q] <= enq_idx;
      fifo_dat[wptr_q] <= enq_dat;
    end
    if (deq)
      mem[fifo_idx[rptr_q]] <= fifo_dat[rptr_q];
  end

  assign datareadmiss = blk_q;
  assign readready    = readready_q;
  assign writeready   = writeready_q;
  assign busy         = busy_q;

endmodule
